// File: rtl/multicycle_main_fsm.sv
// multicycle_main_fsm: main control FSM sequencing fetch/decode/execute/memory/writeback for the multicycle RV32I core
// Inputs : clk, reset (async, active-high), op[6:0] opcode, Zero ALU flag, mem_ready memory handshake
// Outputs: PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc[1:0], ALUSrcA[1:0], ALUSrcB[1:0],
//          ALUOp[1:0] (to ALU_decoder), RegWrite, instr_done pulse, illegal_op sticky flag
// Define ILLEGAL_TRAP_EN to park unsupported opcodes in a TRAP state; otherwise they retire as NOPs.
module multicycle_main_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       RegWrite,
    output logic       instr_done,
    output logic       illegal_op
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECUTER, EXECUTEI, ALUWB, JAL, BEQ, TRAP
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    state_t state;
    logic   illegal_q;
    logic   pc_update;
    logic   branch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                FETCH:    state <= mem_ready ? DECODE : FETCH;
                DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_R:         state <= EXECUTER;
                        OP_I:         state <= EXECUTEI;
                        OP_JAL:       state <= JAL;
                        OP_BEQ:       state <= BEQ;
`ifdef ILLEGAL_TRAP_EN
                        default: begin
                            state     <= TRAP;
                            illegal_q <= 1'b1;
                        end
`else
                        default:      state <= FETCH;
`endif
                    endcase
                end
                MEMADR:   state <= (op == OP_SW) ? MEMWRITE : MEMREAD;
                MEMREAD:  state <= mem_ready ? MEMWB : MEMREAD;
                MEMWRITE: state <= mem_ready ? FETCH : MEMWRITE;
                EXECUTER, EXECUTEI, JAL: state <= ALUWB;
                TRAP:     state <= TRAP;
                default:  state <= FETCH;
            endcase
        end
    end

    // Outputs are decoded combinationally so reset can kill every strobe without waiting for a clock.
    always_comb begin
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        RegWrite   = 1'b0;
        instr_done = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    IRWrite   = mem_ready;
                    pc_update = mem_ready;
                end
                DECODE: begin
                    ALUSrcA    = 2'b01;
                    ALUSrcB    = 2'b01;
`ifndef ILLEGAL_TRAP_EN
                    instr_done = !(op inside {OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ});
`endif
                end
                MEMADR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                end
                MEMREAD:  AdrSrc = 1'b1;
                MEMWB: begin
                    ResultSrc  = 2'b01;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                MEMWRITE: begin
                    AdrSrc     = 1'b1;
                    MemWrite   = 1'b1;
                    instr_done = mem_ready;
                end
                EXECUTER: begin
                    ALUSrcA = 2'b10;
                    ALUOp   = 2'b10;
                end
                EXECUTEI: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    ALUOp   = 2'b10;
                end
                ALUWB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                JAL: begin
                    ALUSrcA   = 2'b01;
                    ALUSrcB   = 2'b10;
                    pc_update = 1'b1;
                end
                BEQ: begin
                    ALUSrcA    = 2'b10;
                    ALUOp      = 2'b01;
                    branch     = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
        PCWrite = pc_update | (branch & Zero);
    end

    assign illegal_op = illegal_q;
endmodule

// File: tb/tb_multicycle_main_fsm.sv
// tb_multicycle_main_fsm: vector table, reset-abort sequence and randomized model check of multicycle_main_fsm
module tb_multicycle_main_fsm;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'd0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal_op;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;

    typedef struct packed {
        logic       pcw, adr, mw, irw;
        logic [1:0] rs, sa, sb, aop;
        logic       rw, done, ill;
    } outs_t;

    typedef struct {
        logic [6:0] op;
        logic       z, mr;
        outs_t      exp;
    } vec_t;

    typedef enum {P_FETCH, P_DEC, P_ADR, P_RD, P_MWB, P_WR, P_EXR, P_EXI, P_AWB, P_JAL, P_BEQ, P_TRAP} phase_t;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011, BAD = 7'b1111111;
`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    // field order: pcw adr mw irw rs sa sb aop rw done ill
    localparam outs_t F1   = 15'b1_0_0_1_10_00_10_00_0_0_0;
    localparam outs_t F0   = 15'b0_0_0_0_10_00_10_00_0_0_0;
    localparam outs_t DEC  = 15'b0_0_0_0_00_01_01_00_0_0_0;
    localparam outs_t DNOP = 15'b0_0_0_0_00_01_01_00_0_1_0;
    localparam outs_t ADR  = 15'b0_0_0_0_00_10_01_00_0_0_0;
    localparam outs_t RD   = 15'b0_1_0_0_00_00_00_00_0_0_0;
    localparam outs_t MWB  = 15'b0_0_0_0_01_00_00_00_1_1_0;
    localparam outs_t WR0  = 15'b0_1_1_0_00_00_00_00_0_0_0;
    localparam outs_t WR1  = 15'b0_1_1_0_00_00_00_00_0_1_0;
    localparam outs_t EXR  = 15'b0_0_0_0_00_10_00_10_0_0_0;
    localparam outs_t EXI  = 15'b0_0_0_0_00_10_01_10_0_0_0;
    localparam outs_t AWB  = 15'b0_0_0_0_00_00_00_00_1_1_0;
    localparam outs_t JLO  = 15'b1_0_0_0_00_01_10_00_0_0_0;
    localparam outs_t BQ1  = 15'b1_0_0_0_00_10_00_01_0_1_0;
    localparam outs_t BQ0  = 15'b0_0_0_0_00_10_00_01_0_1_0;
    localparam outs_t TRP  = 15'b0_0_0_0_00_00_00_00_0_0_1;
    localparam outs_t NONE = 15'b0;

    int     checks = 0;
    int     errors = 0;
    outs_t  act;
    vec_t   tv[$];
    phase_t plan[$];
    logic [6:0] ops [7] = '{LW, SW, RT, IT, JL, BQ, BAD};

    assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp,
                  RegWrite, instr_done, illegal_op};

    multicycle_main_fsm dut (
        .clk(clk), .reset(reset), .op(op), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .RegWrite(RegWrite), .instr_done(instr_done), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    function automatic outs_t o(input logic pcw, adr, mw, irw, input logic [1:0] rs, sa, sb, aop,
                                input logic rw, done, ill);
        return {pcw, adr, mw, irw, rs, sa, sb, aop, rw, done, ill};
    endfunction

    function automatic bit legal(input logic [6:0] v);
        return v inside {LW, SW, RT, IT, JL, BQ};
    endfunction

    function automatic outs_t exp_of(input phase_t p, input logic [6:0] v, input logic mr, z);
        case (p)
            P_FETCH: return o(mr, 0, 0, mr, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0);
            P_DEC:   return o(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, !TRAP_EN && !legal(v), 0);
            P_ADR:   return o(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0, 0);
            P_RD:    return o(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
            P_MWB:   return o(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 1, 0);
            P_WR:    return o(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, mr, 0);
            P_EXR:   return o(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0, 0);
            P_EXI:   return o(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0, 0, 0);
            P_AWB:   return o(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0);
            P_JAL:   return o(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0, 0);
            P_BEQ:   return o(z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0, 1, 0);
            default: return o(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1);
        endcase
    endfunction

    // Plan-based model: each instruction expands into the list of phases it still has to visit.
    task automatic model_step();
        phase_t p = plan[0];
        if ((p == P_FETCH || p == P_RD || p == P_WR) && !mem_ready) return;
        if (p == P_TRAP) return;
        void'(plan.pop_front());
        if (p == P_DEC) begin
            if (op == LW || op == SW) plan.push_back(P_ADR);
            else if (op == RT) begin plan.push_back(P_EXR); plan.push_back(P_AWB); end
            else if (op == IT) begin plan.push_back(P_EXI); plan.push_back(P_AWB); end
            else if (op == JL) begin plan.push_back(P_JAL); plan.push_back(P_AWB); end
            else if (op == BQ) plan.push_back(P_BEQ);
            else if (TRAP_EN) plan.push_back(P_TRAP);
        end else if (p == P_ADR) begin
            if (op == SW) plan.push_back(P_WR);
            else begin plan.push_back(P_RD); plan.push_back(P_MWB); end
        end else if (p == P_FETCH) plan.push_back(P_DEC);
        if (plan.size() == 0) plan.push_back(P_FETCH);
    endtask

    task automatic check(input string name, input outs_t got, input outs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
        end
    endtask

    task automatic add(input logic [6:0] v, input logic z, mr, input outs_t e);
        vec_t r;
        r.op = v; r.z = z; r.mr = mr; r.exp = e;
        tv.push_back(r);
    endtask

    task automatic apply(input string name, input vec_t r);
        op = r.op; Zero = r.z; mem_ready = r.mr;
        @(negedge clk);
        check(name, act, r.exp);
        @(posedge clk);
        #1;
    endtask

    task automatic row(input string name, input logic [6:0] v, input logic z, mr, input outs_t e);
        vec_t r;
        r.op = v; r.z = z; r.mr = mr; r.exp = e;
        apply(name, r);
    endtask

    task automatic do_reset();
        mem_ready = 1'b0;
        #1 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        add(LW, 0, 1, F1);  add(LW, 1, 0, DEC); add(LW, 0, 0, ADR); add(RT, 0, 1, RD);  add(BAD, 1, 0, MWB);
        add(RT, 0, 1, F1);  add(RT, 0, 1, DEC); add(BQ, 1, 0, EXR); add(LW, 0, 0, AWB);
        add(IT, 0, 1, F1);  add(IT, 0, 0, DEC); add(SW, 0, 1, EXI); add(IT, 1, 1, AWB);
        add(BQ, 0, 1, F1);  add(BQ, 1, 1, DEC); add(BQ, 1, 0, BQ1);
        add(BQ, 1, 1, F1);  add(BQ, 0, 1, DEC); add(BQ, 0, 1, BQ0);
        add(BAD, 0, 0, F0); add(LW, 1, 0, F0);  add(SW, 0, 0, F0);  add(JL, 0, 1, F1);
        add(JL, 0, 0, DEC); add(JL, 1, 1, JLO); add(RT, 0, 1, AWB);
        add(SW, 0, 1, F1);  add(SW, 0, 1, DEC); add(SW, 0, 1, ADR); add(LW, 0, 0, WR0); add(LW, 1, 1, WR1);
        add(BAD, 0, 1, F1); add(BAD, 0, 1, TRAP_EN ? DEC : DNOP);   add(BAD, 0, 1, TRAP_EN ? TRP : F1);

        #2;
        check("reset_outputs", act, NONE);
        mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < tv.size(); i++) apply($sformatf("vec%0d", i), tv[i]);

        // sw stalled in MEMWRITE, then reset pulsed between clock edges
        do_reset();
        row("mw_f", SW, 0, 1, F1);
        row("mw_d", SW, 0, 1, DEC);
        row("mw_a", SW, 0, 1, ADR);
        mem_ready = 1'b0;
        @(negedge clk);
        check("mw_stall", act, WR0);
        #2 reset = 1'b1;
        #1 check("mw_async_reset", act, NONE);
        @(negedge clk);
        reset = 1'b0;
        #1 check("mw_release", act, F0);
        @(posedge clk);
        #1;
        row("post_f0a", SW, 0, 0, F0);
        row("post_f0b", SW, 0, 0, F0);
        row("post_f1", SW, 0, 1, F1);
        row("post_dec", SW, 0, 1, DEC);

        do_reset();
        plan.delete();
        plan.push_back(P_FETCH);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
                plan.delete();
                plan.push_back(P_FETCH);
            end
            op = (!TRAP_EN && $urandom_range(0, 7) == 0) ? 7'($urandom)
                                                         : ops[$urandom_range(0, TRAP_EN ? 5 : 6)];
            Zero = 1'($urandom_range(0, 1));
            mem_ready = $urandom_range(0, 3) != 0;
            @(negedge clk);
            check("random", act, exp_of(plan[0], op, mem_ready, Zero));
            model_step();
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_main_fsm.md
Name: multicycle_main_fsm

Overview:
Main control state machine for the multicycle RV32I core. It sits directly upstream of ALU_decoder and drives its ALUOp input.
- Sequences fetch, decode, execute, memory and writeback per instruction from the 7-bit opcode.
- Produces datapath mux selects and write strobes.
- Stalls on a memory-ready handshake.

Parameters:
None; state encoding is internal (4-bit binary).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- op  input  7  opcode from instruction register (instr[6:0])
- Zero  input  1  ALU zero flag
- mem_ready  input  1  memory access completes this cycle
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  instruction register / OldPC enable
- ResultSrc  output  2  00=ALUOut, 01=read data, 10=ALUResult
- ALUSrcA  output  2  00=PC, 01=OldPC, 10=rs1 register
- ALUSrcB  output  2  00=rs2 register, 01=ImmExt, 10=constant 4
- ALUOp  output  2  to ALU_decoder: 00=add, 01=sub, 10=funct-decoded
- RegWrite  output  1  register file write strobe
- instr_done  output  1  one-cycle pulse on the final cycle of each instruction
- illegal_op  output  1  sticky unsupported-opcode flag

Behaviour:
- Reset:
  - Asynchronous entry to FETCH.
  - While reset=1, all outputs are 0; all strobes are forced 0 regardless of state.
  - Reset asserted mid-instruction aborts it immediately; MemWrite and RegWrite drop in the same cycle, no clock needed.
- Outputs are Moore (decoded from state only), except:
  - PCWrite = PCUpdate | (Branch & Zero).
  - FETCH strobes are gated by mem_ready.
- Unlisted outputs are 0 in every state.
- States, outputs and transitions:
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=PCUpdate=mem_ready. Stays in FETCH while mem_ready=0, else goes to DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target).
    - lw 0000011 / sw 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1101111 -> JAL
    - 1100011 -> BEQ
    - any other opcode -> illegal handling (see Optional Feature)
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. lw -> MEMREAD; sw -> MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Holds until mem_ready=1, then -> MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1, instr_done=1 -> FETCH.
  - MEMWRITE: AdrSrc=1, MemWrite=1 (held for every cycle in the state). Holds until mem_ready=1; instr_done=1 in the mem_ready cycle; then -> FETCH.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1, instr_done=1 -> FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 -> ALUWB.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, instr_done=1 -> FETCH.
- Latency with mem_ready held at 1:
  - lw: 5 cycles
  - sw, R-type, I-type, jal: 4 cycles
  - beq: 3 cycles
- Each mem_ready=0 cycle in FETCH/MEMREAD/MEMWRITE adds exactly one cycle.
- op is sampled only in DECODE and MEMADR; changes in other states are ignored.
- mem_ready is ignored outside FETCH/MEMREAD/MEMWRITE.
- Zero is ignored outside BEQ.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined:
  - Unsupported opcode in DECODE -> TRAP state; all strobes 0; no exit except reset.
  - illegal_op goes to 1 on entry to TRAP and holds until reset.
- Undefined:
  - Unsupported opcode in DECODE -> FETCH, with instr_done=1 in the DECODE cycle (treated as a NOP).
  - illegal_op is tied 0.

Test Plan:
- lw (op=0000011), mem_ready=1 -> 5 cycles FETCH, DECODE, MEMADR, MEMREAD, MEMWB. Cycle 5: RegWrite=1, ResultSrc=01, instr_done=1.
- R-type (op=0110011) -> cycle 3: ALUOp=10, ALUSrcA=10, ALUSrcB=00. Cycle 4: RegWrite=1, ResultSrc=00.
- beq (op=1100011):
  - Zero=1 -> cycle 3: ALUOp=01, PCWrite=1.
  - Repeat with Zero=0 -> PCWrite=0, and still returns to FETCH.
- mem_ready=0 for 3 cycles in FETCH, then 1 -> IRWrite=PCWrite=0 for 3 cycles, then exactly one cycle of IRWrite=PCWrite=1, then DECODE.
- sw with mem_ready low, reset pulsed mid-MEMWRITE -> MemWrite falls without a clock edge; after release, state=FETCH and all strobes 0 until mem_ready.
- op=1111111:
  - With ILLEGAL_TRAP_EN -> illegal_op=1 from cycle 3, no further IRWrite.
  - Without ILLEGAL_TRAP_EN -> FETCH in cycle 3, illegal_op=0.
